// File: rtl/ccc_fab_clkgen.sv
// Fabric clock-enable / divided-clock generator: NUM_CH channels, each with a programmable
// divide ratio applied only at period boundaries, plus a global settle-based lock flag.
module ccc_fab_clkgen #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned DIV_W       = 5,
  parameter int unsigned DEFAULT_DIV = 3,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESERN,
  input  logic [NUM_CH*DIV_W-1:0] div_cfg,
  input  logic                    cfg_load,
  input  logic [NUM_CH-1:0]       ch_en,
  output logic [NUM_CH-1:0]       ce_out,
  output logic [NUM_CH-1:0]       clk_out,
  output logic                    cfg_busy,
  output logic                    lock
);

  localparam int unsigned      LockW    = $clog2(LOCK_CYCLES + 1);
  localparam logic [DIV_W-1:0] DefField = DIV_W'(DEFAULT_DIV);
  localparam logic [LockW-1:0] LockMax  = LockW'(LOCK_CYCLES);

  typedef enum logic [1:0] {StIdle, StRun, StPend} ch_state_e;

  ch_state_e        state_q  [NUM_CH];
  ch_state_e        state_d  [NUM_CH];
  logic [DIV_W-1:0] cnt_q    [NUM_CH];
  logic [DIV_W-1:0] cnt_d    [NUM_CH];
  logic [DIV_W-1:0] field_q  [NUM_CH];
  logic [DIV_W-1:0] field_d  [NUM_CH];
  logic [DIV_W-1:0] shadow_q [NUM_CH];
  logic [DIV_W-1:0] shadow_d [NUM_CH];
  logic [DIV_W-1:0] cfg      [NUM_CH];
  logic [NUM_CH-1:0] ce_q, ce_d, clk_q, clk_d;
  logic              busy_q, busy_d;
  logic [LockW-1:0]  lock_cnt_q, lock_cnt_d;

  // Outside PEND the shadow always equals the active field, so every point where a new
  // ratio may take effect (idle, abort, wrap) simply copies the shadow.
  always_comb begin
    busy_d = cfg_load;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cfg[i]      = div_cfg[i*DIV_W +: DIV_W];
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      field_d[i]  = field_q[i];
      shadow_d[i] = cfg_load ? cfg[i] : shadow_q[i];
      ce_d[i]     = 1'b0;
      clk_d[i]    = 1'b0;
      unique case (state_q[i])
        StIdle: begin
          field_d[i] = shadow_d[i];
          cnt_d[i]   = '0;
          if (ch_en[i]) begin
            state_d[i] = StRun;
            clk_d[i]   = 1'b1;
          end
        end
        default: begin
          if (!ch_en[i]) begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
            field_d[i] = shadow_d[i];
          end else if (cnt_q[i] == field_q[i]) begin
            state_d[i] = StRun;
            cnt_d[i]   = '0;
            field_d[i] = shadow_d[i];
            ce_d[i]    = 1'b1;
            clk_d[i]   = 1'b1;
          end else begin
            if (cfg_load) state_d[i] = StPend;
            cnt_d[i] = cnt_q[i] + DIV_W'(1);
            // High while count < ceil(N/2), i.e. count <= field/2.
            clk_d[i] = (cnt_d[i] <= (field_q[i] >> 1));
          end
        end
      endcase
      busy_d = busy_d | (state_d[i] == StPend);
    end
  end

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (cfg_load || busy_q) begin
      lock_cnt_d = '0;
    end else if (lock_cnt_q != LockMax) begin
      lock_cnt_d = lock_cnt_q + LockW'(1);
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= StIdle;
        cnt_q[i]    <= '0;
        field_q[i]  <= DefField;
        shadow_q[i] <= DefField;
      end
      ce_q       <= '0;
      clk_q      <= '0;
      busy_q     <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      field_q    <= field_d;
      shadow_q   <= shadow_d;
      ce_q       <= ce_d;
      clk_q      <= clk_d;
      busy_q     <= busy_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign ce_out   = ce_q;
  assign clk_out  = clk_q;
  assign cfg_busy = busy_q;
  assign lock     = (lock_cnt_q == LockMax);

endmodule

// File: tb/tb_ccc_fab_clkgen.sv
// Bench for ccc_fab_clkgen: a timestamp-based period model checked every cycle, plus
// directed scenarios with hand-computed periods, duty cycles and lock timing.
module tb_ccc_fab_clkgen;

  localparam int NumCh = 3;
  localparam int DivW  = 5;
  localparam int DefN  = 4;
  localparam int LockC = 16;

  logic                  PCLK = 1'b0;
  logic                  PRESERN;
  logic [NumCh*DivW-1:0] div_cfg;
  logic                  cfg_load;
  logic [NumCh-1:0]      ch_en;
  logic [NumCh-1:0]      ce_out, clk_out;
  logic                  cfg_busy, lock;

  ccc_fab_clkgen #(
    .NUM_CH(NumCh), .DIV_W(DivW), .DEFAULT_DIV(DefN - 1), .LOCK_CYCLES(LockC)
  ) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .div_cfg(div_cfg), .cfg_load(cfg_load), .ch_en(ch_en),
    .ce_out(ce_out), .clk_out(clk_out), .cfg_busy(cfg_busy), .lock(lock)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each running channel remembers when its current period began and its ratio N.
  int             t = 0;
  int             m_n[NumCh], m_sh[NumCh], m_t0[NumCh];
  bit             m_run[NumCh], m_pend[NumCh];
  logic [NumCh-1:0] e_ce, e_clk;
  logic           e_busy, e_lock;
  int             lock_age;
  bit             chk_on = 0;
  bit             any_pend;

  always @(posedge PCLK) begin
    t++;
    if (!PRESERN) begin
      chk_on   = 1;
      lock_age = 0;
      e_busy   = 0;
      for (int c = 0; c < NumCh; c++) begin
        m_run[c] = 0; m_pend[c] = 0; m_n[c] = DefN; m_sh[c] = DefN;
        e_ce[c]  = 0; e_clk[c] = 0;
      end
    end else begin
      if (cfg_load || e_busy) lock_age = 0;
      else if (lock_age < LockC) lock_age++;
      any_pend = 0;
      for (int c = 0; c < NumCh; c++) begin
        if (cfg_load) begin
          m_sh[c]   = int'(div_cfg[c*DivW +: DivW]) + 1;
          m_pend[c] = 1;
        end
        e_ce[c]  = 0;
        e_clk[c] = 0;
        if (!ch_en[c] || !m_run[c]) begin
          if (m_pend[c]) begin m_n[c] = m_sh[c]; m_pend[c] = 0; end
          m_run[c] = ch_en[c];
          if (ch_en[c]) begin m_t0[c] = t; e_clk[c] = 1; end
        end else begin
          if (t - m_t0[c] == m_n[c]) begin
            m_t0[c] = t;
            e_ce[c] = 1;
            if (m_pend[c]) begin m_n[c] = m_sh[c]; m_pend[c] = 0; end
          end
          e_clk[c] = ((t - m_t0[c]) < (m_n[c] + 1) / 2);
        end
        any_pend |= m_pend[c];
      end
      e_busy = cfg_load | any_pend;
    end
    e_lock = (lock_age == LockC);
  end

  always @(negedge PCLK) begin
    if (chk_on) begin
      check("model_ce", ce_out, e_ce);
      check("model_clk", clk_out, e_clk);
      check("model_busy", cfg_busy, e_busy);
      check("model_lock", lock, e_lock);
    end
  end

  task automatic wait_ce(input int ch);
    int w = 0;
    while (ce_out[ch] !== 1'b1 && w < 200) begin @(negedge PCLK); w++; end
    if (w >= 200) check("wait_ce_timeout", 0, 1);
  endtask

  // Period and high-phase length of one full period starting at the next ce pulse.
  task automatic measure(input int ch, output int per, output int hi);
    per = 0;
    hi  = 0;
    wait_ce(ch);
    do begin
      if (clk_out[ch] === 1'b1) hi++;
      per++;
      @(negedge PCLK);
    end while (ce_out[ch] !== 1'b1 && per < 200);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, h, c;
    PRESERN = 1'b0; ch_en = '0; div_cfg = '0; cfg_load = 1'b0;
    repeat (3) @(negedge PCLK);
    check("rst_lock", lock, 0);
    check("rst_ce", ce_out, 0);
    check("rst_clk", clk_out, 0);
    check("rst_busy", cfg_busy, 0);

    // Defaults, all channels running.
    PRESERN = 1'b1; ch_en = 3'b111;
    for (int k = 1; k <= 16; k++) begin
      @(negedge PCLK);
      if (k == 1) check("start_clk", clk_out, 3'b111);
      if (k == 4) check("def_low", clk_out, 3'b000);
      if (k == 5) check("def_ce", ce_out, 3'b111);
      if (k == 15) check("lock_early", lock, 0);
    end
    check("lock_at_16", lock, 1);
    measure(0, p, h);
    check("def_per", p, 4);
    check("def_hi", h, 2);

    // Load {31, 4, 0}.
    div_cfg = {5'd31, 5'd4, 5'd0}; cfg_load = 1'b1;
    @(negedge PCLK);
    cfg_load = 1'b0;
    check("busy_set", cfg_busy, 1);
    check("lock_drop", lock, 0);
    c = 0;
    while (cfg_busy === 1'b1 && c < 100) begin @(negedge PCLK); c++; end
    c = 0;
    while (lock !== 1'b1 && c < 100) begin @(negedge PCLK); c++; end
    check("relock_delay", c, 16);
    measure(0, p, h);
    check("n1_per", p, 1);
    check("n1_hi", h, 1);
    measure(1, p, h);
    check("n5_per", p, 5);
    check("n5_hi", h, 3);
    measure(2, p, h);
    check("n32_per", p, 32);
    check("n32_hi", h, 16);

    // Back to /4, then 4 followed by 7 two cycles later: latest wins.
    div_cfg = {5'd3, 5'd3, 5'd3}; cfg_load = 1'b1;
    @(negedge PCLK);
    cfg_load = 1'b0;
    c = 0;
    while (cfg_busy === 1'b1 && c < 100) begin @(negedge PCLK); c++; end
    check("busy_clear", cfg_busy, 0);
    wait_ce(1);
    div_cfg = {5'd4, 5'd4, 5'd4}; cfg_load = 1'b1;
    @(negedge PCLK);
    cfg_load = 1'b0;
    @(negedge PCLK);
    div_cfg = {5'd7, 5'd7, 5'd7}; cfg_load = 1'b1;
    @(negedge PCLK);
    cfg_load = 1'b0;
    measure(1, p, h);
    check("latest_per", p, 8);
    check("latest_hi", h, 4);

    // Load exactly at ch1's terminal count; others idle.
    ch_en = 3'b010;
    wait_ce(1);
    repeat (7) @(negedge PCLK);
    div_cfg = {5'd0, 5'd2, 5'd0}; cfg_load = 1'b1;
    @(negedge PCLK);
    cfg_load = 1'b0;
    check("term_busy", cfg_busy, 1);
    check("term_ce", ce_out[1], 1);
    @(negedge PCLK);
    check("term_busy_off", cfg_busy, 0);
    measure(1, p, h);
    check("term_per", p, 3);
    check("term_hi", h, 2);

    // Abort with a pending load, then re-enable.
    wait_ce(1);
    div_cfg = {5'd0, 5'd5, 5'd0}; cfg_load = 1'b1;
    @(negedge PCLK);
    cfg_load = 1'b0; ch_en = 3'b000;
    check("pend_busy", cfg_busy, 1);
    @(negedge PCLK);
    check("abort_clk", clk_out, 0);
    check("abort_ce", ce_out, 0);
    check("abort_busy", cfg_busy, 0);
    repeat (2) @(negedge PCLK);
    ch_en = 3'b010;
    for (int k = 1; k <= 7; k++) begin
      @(negedge PCLK);
      check("reen_clk", clk_out[1], (k <= 3) || (k == 7));
      check("reen_ce", ce_out[1], k == 7);
    end

    // Reset mid-period.
    ch_en = 3'b111; div_cfg = {5'd1, 5'd1, 5'd1};
    repeat (5) @(negedge PCLK);
    cfg_load = 1'b1;
    @(negedge PCLK);
    cfg_load = 1'b0;
    @(negedge PCLK);
    PRESERN = 1'b0;
    @(negedge PCLK);
    check("rst_mid_ce", ce_out, 0);
    check("rst_mid_clk", clk_out, 0);
    check("rst_mid_busy", cfg_busy, 0);
    check("rst_mid_lock", lock, 0);
    PRESERN = 1'b1;
    measure(2, p, h);
    check("rst_def_per", p, 4);
    check("rst_def_hi", h, 2);
    measure(1, p, h);
    check("rst_def_per1", p, 4);

    repeat (3) @(negedge PCLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ccc_fab_clkgen.md
# ccc_fab_clkgen

Parametrised fabric clock-enable and divided-clock generator fed by the MSS CCC fabric clock (RCOSC-derived). It generalises the CCC's fixed bypass output dividers into NUM_CH independent channels. Each channel has a run-time programmable divide ratio, a per-channel enable and glitch-free ratio changes. A global lock flag gates downstream logic until all channels are stable.

## Interface
Parameters:
- NUM_CH, 3, number of output channels (1..8)
- DIV_W, 5, width of each divide field; ratio N = field + 1 (1..2^DIV_W)
- DEFAULT_DIV, 3, divide field loaded into every channel at reset (N = 4)
- LOCK_CYCLES, 16, settle cycles before lock asserts (≥1)

Ports:
- PCLK  in  1  fabric clock, all logic on rising edge
- PRESERN  in  1  reset, synchronous, active-low
- div_cfg  in  NUM_CH*DIV_W  new divide fields; channel i at [i*DIV_W +: DIV_W]
- cfg_load  in  1  one-cycle strobe; captures div_cfg into shadow registers
- ch_en  in  NUM_CH  per-channel run enable
- ce_out  out  NUM_CH  one-cycle clock-enable pulse per divided period
- clk_out  out  NUM_CH  registered divided clock (fabric route only, not a global)
- cfg_busy  out  1  high while any channel has a pending shadow value
- lock  out  1  all channels stable on current configuration

## Operation
- Reset (PRESERN=0 at a rising edge): active and shadow fields = DEFAULT_DIV; counters = 0; ce_out, clk_out, cfg_busy, lock = 0; lock counter = 0.
- Per-channel states:
  - IDLE: ch_en=0. Counter held at 0, ce_out=0, clk_out=0. Pending shadow is applied immediately.
  - RUN: counter counts 0..N-1 and wraps.
  - PEND: RUN with a shadow value waiting.
- Transitions: IDLE→RUN on ch_en=1. RUN→PEND on cfg_load. PEND→RUN at the terminal count (count==N-1), where the active field takes the shadow value and the counter wraps to 0. Any state→IDLE on ch_en=0, which aborts the period without a runt pulse.
- ce_out[i] = 1 for exactly one cycle per period, registered, aligned with the counter wrap.
- clk_out[i] = 1 while count < ceil(N/2), else 0. N=1: ce_out and clk_out constantly 1 while running. N=2: 50% duty.
- Glitch-free rule: a ratio never changes mid-period. Every high and low phase of clk_out belongs entirely to either the old or the new N.
- cfg_load while PEND: shadow is overwritten and the latest value wins. cfg_load in the same cycle as the terminal count: the new value applies at that wrap.
- cfg_load captures all channels, including those whose field is unchanged. Those channels pass through PEND for one period.
- cfg_busy = OR of per-channel PEND.
- Lock: counter clears on reset, on cfg_load, and while cfg_busy=1. It increments otherwise and saturates at LOCK_CYCLES. lock = (counter == LOCK_CYCLES). A ch_en change does not drop lock.
- Counter widths are DIV_W bits. The wrap compare uses the DIV_W-bit field value, so field 2^DIV_W-1 gives N = 2^DIV_W with no overflow.

## Timing
- With ch_en sampled high at edge E0: clk_out rises at E0+1. First ce_out is high in the cycle after edge E0+N. Subsequent ce_out pulses follow every N cycles.
- ch_en sampled low at edge E: ce_out and clk_out are 0 from E+1.
- cfg_load sampled at edge E: cfg_busy = 1 from E+1. cfg_busy falls the cycle after the last channel wraps. Worst-case delay is N_old cycles.
- lock rises LOCK_CYCLES cycles after cfg_busy falls. After reset release, lock rises at cycle LOCK_CYCLES.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Reset, all ch_en=1, defaults: every channel gives ce_out once per 4 cycles, and clk_out runs 2 high / 2 low. lock rises 16 cycles after PRESERN goes high. cfg_busy stays 0.
- Load fields {0, 4, 31}: ch0 ce_out is constant 1. ch1 has period 5 with clk_out 3 high / 2 low. ch2 has period 32 with 16/16. Each change takes effect only at that channel's old wrap. lock drops, then returns 16 cycles after cfg_busy falls.
- cfg_load with 4, then with 7 two cycles later on a channel running /4: no period of 5 ever appears. The first new period is 8.
- cfg_load exactly at a terminal count: the next period already uses the new N, and cfg_busy pulses for one cycle only.
- Drop ch_en mid-period with a load pending: outputs go to 0 next cycle and the shadow is applied. Re-enable: the first period uses the new N with full-width phases.
- Assert PRESERN low mid-period: all outputs are 0 on the next cycle, and fields return to DEFAULT_DIV.
